cam_capture_pack: RTL and testbench
===================================

CAM_CAPTURE_PACK -- requirements
Module: cam_capture_pack

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: output beat width in bits.
REQ-002 SHALL have parameter BYTES_PER_PIXEL, default 2: camera bytes per pixel (1..4).
REQ-003 SHALL have parameter H_ACTIVE, default 640: pixels per line.
REQ-004 SHALL have parameter V_ACTIVE, default 480: lines per frame.
REQ-005 SHALL have parameter CNT_WIDTH, default 12: width of the line and byte counters.
REQ-006 SHALL derive PIXELS_PER_BEAT = DATA_WIDTH/(8*BYTES_PER_PIXEL), and SHALL require H_ACTIVE to be an integer multiple of PIXELS_PER_BEAT.
REQ-007 SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
  i_pclk  in  1  pixel clock; all logic runs on its rising edge.
  i_rstn  in  1  asynchronous active-low reset.
  i_enable  in  1  capture enable (config done).
  i_vsync  in  1  frame sync, high between frames.
  i_href  in  1  line-valid.
  i_data  in  8  camera byte.
  i_tready  in  1  AXIS ready.
  o_tvalid  out  1  AXIS valid.
  o_tdata  out  DATA_WIDTH  packed pixels.
  o_tuser  out  1  start of frame.
  o_tlast  out  1  end of line.
  i_clr_status  in  1  synchronous clear of the sticky flags.
  o_overflow  out  1  sticky: a beat was lost.
  o_frame_err  out  1  sticky: line or frame size error.
  o_frame_cnt  out  16  count of completed good frames (wraps).

Function
REQ-008 SHALL implement FSM states IDLE, WAIT_SOF, ACTIVE and DROP.
REQ-009 IDLE -> WAIT_SOF when i_enable=1.
REQ-010 WAIT_SOF -> ACTIVE on a falling edge of i_vsync (registered previous value 1, current 0).
REQ-011 ACTIVE -> WAIT_SOF on a rising edge of i_vsync.
REQ-012 ACTIVE -> DROP on overflow (REQ-017).
REQ-013 DROP -> WAIT_SOF on a rising edge of i_vsync.
REQ-014 Any state -> IDLE when i_enable=0; the partial beat is discarded, and a pending o_tvalid is held until the handshake completes.
REQ-015 In ACTIVE, SHALL sample i_data on every cycle with i_href=1.
  - The first byte of each pixel lands in the most significant byte of the pixel.
  - Pixel k of a beat occupies bits [(k+1)*8*BYTES_PER_PIXEL-1 : k*8*BYTES_PER_PIXEL].
REQ-016 When the last byte of a beat is sampled, the beat SHALL be loaded into the output register, and o_tvalid SHALL assert on the next cycle (latency 1).
REQ-017 If the output register is still full (o_tvalid=1 and i_tready=0) when a new beat completes:
  - the new beat is dropped;
  - o_overflow is set;
  - the FSM enters DROP.
  The held beat is kept and its handshake still completes.
REQ-018 o_tvalid, o_tdata, o_tuser and o_tlast SHALL stay stable while o_tvalid=1 and i_tready=0, and SHALL clear (valid=0) on the handshake unless a new beat loads in the same cycle.
REQ-019 o_tuser SHALL be 1 only on the first beat of line 0 of each frame.
REQ-020 o_tlast SHALL be 1 on the beat holding pixel H_ACTIVE-1 of each line.
REQ-021 On a falling edge of i_href with a short line:
  - the partial beat is zero-padded and emitted with o_tlast=1;
  - o_frame_err is set.
  Bytes beyond H_ACTIVE*BYTES_PER_PIXEL in a line SHALL be discarded, and o_frame_err set.
REQ-022 The line counter SHALL increment on each falling edge of i_href in ACTIVE.
REQ-023 At a rising edge of i_vsync in ACTIVE:
  - if the line count equals V_ACTIVE and no error occurred this frame, o_frame_cnt increments (16-bit wrap);
  - otherwise o_frame_err is set.
REQ-024 A rising edge of i_vsync while i_href=1 SHALL abort the line, discard the partial beat, and set o_frame_err.
REQ-025 i_clr_status=1 SHALL clear o_overflow and o_frame_err; a set event in the same cycle SHALL win.

Reset
REQ-026 While i_rstn=0, SHALL hold the following state:
  - FSM in IDLE;
  - o_tvalid, o_tuser, o_tlast, o_overflow, o_frame_err = 0;
  - o_tdata = 0;
  - o_frame_cnt = 0;
  - all counters = 0.
REQ-027 Assertion of reset mid-frame SHALL drop all state immediately.
  - After release, capture restarts only from WAIT_SOF on the next falling edge of i_vsync.

Verification (H_ACTIVE=4, V_ACTIVE=2, DATA_WIDTH=32, BYTES_PER_PIXEL=2, i_tready=1)
REQ-028 Good frame: bytes 01..10 over 2 lines of 8 bytes ->
  - beats 0x03040102 (tuser=1), 0x07080506 (tlast=1), 0x0B0C090A, 0x0F100D0E (tlast=1);
  - o_frame_cnt=1.
REQ-029 Backpressure: i_tready=0 for 6 cycles from the first beat ->
  - the first beat is held stable;
  - the second beat is dropped;
  - o_overflow=1;
  - no further beats until the next frame.
REQ-030 Short line of 6 bytes 01..06 ->
  - beats 0x03040102, then 0x00000506 with tlast=1;
  - o_frame_err=1;
  - o_frame_cnt unchanged.
REQ-031 i_vsync rises after 1 line ->
  - o_frame_err=1;
  - o_frame_cnt unchanged;
  - the next good frame increments the count.
REQ-032 i_rstn pulsed low mid-line ->
  - all outputs 0 during reset;
  - no beat emitted until after the next falling edge of i_vsync.
REQ-033 i_enable dropped while o_tvalid=1 and i_tready=0 ->
  - o_tvalid is held until i_tready=1, then 0;
  - the FSM is in IDLE.

Source files
------------

// File: rtl/cam_capture_pack.sv
// Camera byte-stream capture: packs DVP-style bytes into AXI-Stream beats
// with frame/line markers, overflow detection and frame-size checking.
module cam_capture_pack #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int CNT_WIDTH       = 12
) (
    input  logic                  i_pclk,
    input  logic                  i_rstn,
    input  logic                  i_enable,
    input  logic                  i_vsync,
    input  logic                  i_href,
    input  logic [7:0]            i_data,
    input  logic                  i_tready,
    output logic                  o_tvalid,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tuser,
    output logic                  o_tlast,
    input  logic                  i_clr_status,
    output logic                  o_overflow,
    output logic                  o_frame_err,
    output logic [15:0]           o_frame_cnt
);

    localparam int PIXELS_PER_BEAT = DATA_WIDTH / (8 * BYTES_PER_PIXEL);
    localparam int BYTES_PER_BEAT  = PIXELS_PER_BEAT * BYTES_PER_PIXEL;
    localparam int LINE_BYTES      = H_ACTIVE * BYTES_PER_PIXEL;
    localparam int LANE_W = (BYTES_PER_BEAT > 1) ? $clog2(BYTES_PER_BEAT) : 1;

    localparam logic [CNT_WIDTH-1:0] LINE_BYTES_C = CNT_WIDTH'(LINE_BYTES);
    localparam logic [CNT_WIDTH-1:0] LAST_BYTE_C  = CNT_WIDTH'(LINE_BYTES - 1);
    localparam logic [CNT_WIDTH-1:0] BEAT_BYTES_C = CNT_WIDTH'(BYTES_PER_BEAT);
    localparam logic [CNT_WIDTH-1:0] V_LINES_C    = CNT_WIDTH'(V_ACTIVE);
    localparam logic [LANE_W-1:0]    LAST_LANE_C  = LANE_W'(BYTES_PER_BEAT - 1);

    if (H_ACTIVE % PIXELS_PER_BEAT != 0) begin : g_bad_h_active
        $error("H_ACTIVE must be a multiple of the pixels per beat");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        ACTIVE,
        DROP
    } state_t;

    state_t                  state;
    logic                    vsync_d;
    logic                    href_d;
    logic [CNT_WIDTH-1:0]    byte_cnt;
    logic [CNT_WIDTH-1:0]    line_cnt;
    logic [LANE_W-1:0]       lane;
    logic [DATA_WIDTH-1:0]   pack;
    logic                    bad;

    logic                    vs_rise;
    logic                    vs_fall;
    logic                    href_fall;
    logic                    in_line;
    logic                    sample;
    logic                    keep;
    logic                    extra;
    logic                    full_done;
    logic                    short_line;
    logic                    short_done;
    logic                    done;
    logic                    out_free;
    logic                    load;
    logic                    ovf;
    logic                    first_beat;
    logic                    last_beat;
    logic [CNT_WIDTH-1:0]    line_total;
    logic                    frame_end;
    logic                    frame_good;
    logic                    err_set;
    logic [DATA_WIDTH-1:0]   beat;
    logic [DATA_WIDTH-1:0]   emit;

    assign vs_rise   = i_vsync & ~vsync_d;
    assign vs_fall   = ~i_vsync & vsync_d;
    assign href_fall = href_d & ~i_href;
    assign in_line   = (state == ACTIVE) & i_enable;

    // A vsync rise with href high aborts the line, so no byte is taken then.
    assign sample     = in_line & i_href & ~vs_rise;
    assign keep       = sample & (byte_cnt < LINE_BYTES_C);
    assign extra      = sample & ~keep;
    assign full_done  = keep & (lane == LAST_LANE_C);
    assign short_line = in_line & href_fall & (byte_cnt < LINE_BYTES_C);
    assign short_done = short_line & ~vs_rise & (lane != '0);
    assign done       = full_done | short_done;

    assign out_free = ~o_tvalid | i_tready;
    assign load     = done & out_free;
    assign ovf      = done & ~out_free;

    assign first_beat = (line_cnt == '0) & (byte_cnt < BEAT_BYTES_C);
    assign last_beat  = short_done | (byte_cnt == LAST_BYTE_C);

    assign line_total = line_cnt + CNT_WIDTH'(href_fall);
    assign frame_end  = in_line & vs_rise;
    assign frame_good = ~bad & ~short_line & ~i_href
                      & (line_total == V_LINES_C);
    assign err_set    = extra | short_line | (frame_end & ~frame_good);

    // First byte of a pixel goes to the pixel's most significant byte.
    always_comb begin
        beat = pack;
        for (int b = 0; b < BYTES_PER_BEAT; b++) begin
            if (lane == LANE_W'(b)) begin
                beat[((b / BYTES_PER_PIXEL) * BYTES_PER_PIXEL
                      + BYTES_PER_PIXEL - 1
                      - (b % BYTES_PER_PIXEL)) * 8 +: 8] = i_data;
            end
        end
    end

    assign emit = full_done ? beat : pack;

    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            vsync_d     <= 1'b0;
            href_d      <= 1'b0;
            byte_cnt    <= '0;
            line_cnt    <= '0;
            lane        <= '0;
            pack        <= '0;
            bad         <= 1'b0;
            o_tvalid    <= 1'b0;
            o_tdata     <= '0;
            o_tuser     <= 1'b0;
            o_tlast     <= 1'b0;
            o_overflow  <= 1'b0;
            o_frame_err <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            vsync_d <= i_vsync;
            href_d  <= i_href;

            if (load) begin
                o_tvalid <= 1'b1;
                o_tdata  <= emit;
                o_tuser  <= first_beat;
                o_tlast  <= last_beat;
            end else if (i_tready) begin
                o_tvalid <= 1'b0;
            end

            o_overflow  <= ovf | (o_overflow & ~i_clr_status);
            o_frame_err <= err_set | (o_frame_err & ~i_clr_status);

            if (frame_end && frame_good) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end

            if (!i_enable) begin
                state    <= IDLE;
                byte_cnt <= '0;
                line_cnt <= '0;
                lane     <= '0;
                pack     <= '0;
                bad      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= WAIT_SOF;
                    end
                    WAIT_SOF: begin
                        if (vs_fall) begin
                            state    <= ACTIVE;
                            byte_cnt <= '0;
                            line_cnt <= '0;
                            lane     <= '0;
                            pack     <= '0;
                            bad      <= 1'b0;
                        end
                    end
                    ACTIVE: begin
                        if (vs_rise) begin
                            state <= WAIT_SOF;
                            lane  <= '0;
                            pack  <= '0;
                        end else begin
                            if (ovf) begin
                                state <= DROP;
                            end
                            if (keep) begin
                                byte_cnt <= byte_cnt + CNT_WIDTH'(1);
                                if (full_done) begin
                                    lane <= '0;
                                    pack <= '0;
                                end else begin
                                    lane <= lane + LANE_W'(1);
                                    pack <= beat;
                                end
                            end
                            if (extra) begin
                                bad <= 1'b1;
                            end
                            if (href_fall) begin
                                line_cnt <= line_cnt + CNT_WIDTH'(1);
                                byte_cnt <= '0;
                                lane     <= '0;
                                pack     <= '0;
                                if (short_line) begin
                                    bad <= 1'b1;
                                end
                            end
                        end
                    end
                    DROP: begin
                        if (vs_rise) begin
                            state <= WAIT_SOF;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_pack.sv
// Bench for cam_capture_pack: directed frame table, multi-cycle corner
// sequences and random frames checked against a pixel-level model.
module tb_cam_capture_pack;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int LB = 8;

    typedef struct packed {
        logic [31:0] d;
        logic        u;
        logic        l;
    } beat_t;

    typedef struct {
        string       name;
        int          nl;
        int          len;
        int          nbeats;
        logic [31:0] first;
        logic [31:0] last_d;
        logic        inc;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        enable = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        tready = 1'b1;
    logic        clr = 1'b0;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tuser;
    logic        tlast;
    logic        overflow;
    logic        frame_err;
    logic [15:0] frame_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  fb [4][16];
    int          lens [4];
    beat_t       got [$];
    beat_t       expq [$];
    logic [15:0] exp_cnt = 16'd0;
    logic        exp_err;
    logic        held = 1'b0;
    logic [33:0] held_v;

    cam_capture_pack #(
        .DATA_WIDTH(32),
        .BYTES_PER_PIXEL(2),
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .CNT_WIDTH(12)
    ) dut (
        .i_pclk(clk),
        .i_rstn(rstn),
        .i_enable(enable),
        .i_vsync(vsync),
        .i_href(href),
        .i_data(data),
        .i_tready(tready),
        .o_tvalid(tvalid),
        .o_tdata(tdata),
        .o_tuser(tuser),
        .o_tlast(tlast),
        .i_clr_status(clr),
        .o_overflow(overflow),
        .o_frame_err(frame_err),
        .o_frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Output monitor: collects handshakes and checks stability under stall.
    always @(negedge clk) begin
        if (held) begin
            chk("hold_valid", 64'(tvalid), 64'd1);
            chk("hold_beat", 64'({tdata, tuser, tlast}), 64'(held_v));
        end
        held = rstn && tvalid && !tready;
        held_v = {tdata, tuser, tlast};
        if (rstn && tvalid && tready) begin
            got.push_back('{d: tdata, u: tuser, l: tlast});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic fill_seq(input int len);
        int k = 1;
        for (int l = 0; l < 4; l++) begin
            lens[l] = len;
            for (int b = 0; b < 16; b++) begin
                fb[l][b] = 8'(k);
                if (b < len) k++;
            end
        end
    endtask

    task automatic send_line(input int l);
        for (int b = 0; b < lens[l]; b++) begin
            href = 1'b1;
            data = fb[l][b];
            tick();
        end
        href = 1'b0;
        data = 8'h00;
        repeat (4) tick();
    endtask

    task automatic send_frame(input int nl);
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
        for (int l = 0; l < nl; l++) send_line(l);
        vsync = 1'b1;
        repeat (4) tick();
    endtask

    // Reference: pixels are (first byte << 8 | second byte), pixel k at 16*k.
    task automatic build_model(input int nl);
        logic good;
        good = (nl == V);
        expq.delete();
        for (int l = 0; l < nl; l++) begin
            int n;
            int nb;
            n = (lens[l] < LB) ? lens[l] : LB;
            if (lens[l] != LB) good = 1'b0;
            nb = (n + 3) / 4;
            for (int c = 0; c < nb; c++) begin
                logic [31:0] w;
                beat_t       e;
                w = 32'd0;
                for (int px = 0; px < 2; px++) begin
                    int   hi_i;
                    logic [7:0] hi;
                    logic [7:0] lo;
                    hi_i = c * 4 + px * 2;
                    hi = (hi_i < n) ? fb[l][hi_i] : 8'h00;
                    lo = (hi_i + 1 < n) ? fb[l][hi_i + 1] : 8'h00;
                    w = w | (32'({hi, lo}) << (16 * px));
                end
                e.d = w;
                e.u = (l == 0) && (c == 0);
                e.l = (c * 4 + 4 == LB)
                   || ((c == nb - 1) && (n < LB) && (n % 4 != 0));
                expq.push_back(e);
            end
        end
        exp_err = !good;
        if (good) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic compare_model(input string tag);
        int m;
        chk({tag, "_nbeats"}, 64'(got.size()), 64'(expq.size()));
        m = (got.size() < expq.size()) ? got.size() : expq.size();
        for (int i = 0; i < m; i++) begin
            chk({tag, "_beat"}, 64'(got[i]), 64'(expq[i]));
        end
        chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_cnt));
        chk({tag, "_frame_err"}, 64'(frame_err), 64'(exp_err));
    endtask

    task automatic good_frame(input string tag);
        fill_seq(LB);
        pulse_clr();
        got.delete();
        build_model(V);
        send_frame(V);
        compare_model(tag);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (tvalid !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk({tag, "_wait_valid"}, 64'(k < 100), 64'd1);
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{"good", 2, 8, 4, 32'h03040102, 32'h0F100D0E, 1'b1, 1'b0};
        vecs[1] = '{"short", 1, 6, 2, 32'h03040102, 32'h00000506, 1'b0, 1'b1};
        vecs[2] = '{"one_line", 1, 8, 2, 32'h03040102, 32'h07080506, 1'b0, 1'b1};
        vecs[3] = '{"long", 2, 10, 4, 32'h03040102, 32'h11120F10, 1'b0, 1'b1};
        vecs[4] = '{"recover", 2, 8, 4, 32'h03040102, 32'h0F100D0E, 1'b1, 1'b0};

        #1 rstn = 1'b0;
        repeat (3) tick();
        chk("reset_tvalid", 64'(tvalid), 64'd0);
        chk("reset_tdata", 64'(tdata), 64'd0);
        chk("reset_tuser", 64'(tuser), 64'd0);
        chk("reset_tlast", 64'(tlast), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_frame_err", 64'(frame_err), 64'd0);
        chk("reset_frame_cnt", 64'(frame_cnt), 64'd0);
        rstn = 1'b1;
        enable = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 5; i++) begin
            fill_seq(vecs[i].len);
            pulse_clr();
            got.delete();
            send_frame(vecs[i].nl);
            if (vecs[i].inc) exp_cnt = exp_cnt + 16'd1;
            chk({vecs[i].name, "_nbeats"}, 64'(got.size()),
                64'(vecs[i].nbeats));
            if (got.size() > 0) begin
                chk({vecs[i].name, "_first"}, 64'(got[0].d),
                    64'(vecs[i].first));
                chk({vecs[i].name, "_tuser"}, 64'(got[0].u), 64'd1);
                chk({vecs[i].name, "_last"}, 64'(got[got.size() - 1].d),
                    64'(vecs[i].last_d));
                chk({vecs[i].name, "_tlast"}, 64'(got[got.size() - 1].l),
                    64'd1);
            end
            chk({vecs[i].name, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_cnt));
            chk({vecs[i].name, "_frame_err"}, 64'(frame_err),
                64'(vecs[i].err));
        end

        // Backpressure: six stalled cycles starting at the first beat.
        fill_seq(LB);
        pulse_clr();
        got.delete();
        fork
            send_frame(V);
            begin
                wait_valid("bp");
                tready = 1'b0;
                repeat (6) tick();
                tready = 1'b1;
            end
        join
        chk("bp_nbeats", 64'(got.size()), 64'd1);
        if (got.size() > 0) begin
            chk("bp_beat", 64'(got[0]), 64'({32'h03040102, 1'b1, 1'b0}));
        end
        chk("bp_overflow", 64'(overflow), 64'd1);
        chk("bp_frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
        good_frame("bp_next");
        chk("bp_next_overflow", 64'(overflow), 64'd0);

        // Reset pulsed mid-line.
        pulse_clr();
        got.delete();
        fill_seq(LB);
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
        for (int b = 0; b < 3; b++) begin
            href = 1'b1;
            data = fb[0][b];
            tick();
        end
        rstn = 1'b0;
        #1;
        chk("mrst_tvalid", 64'(tvalid), 64'd0);
        chk("mrst_tdata", 64'(tdata), 64'd0);
        chk("mrst_tuser", 64'(tuser), 64'd0);
        chk("mrst_tlast", 64'(tlast), 64'd0);
        chk("mrst_overflow", 64'(overflow), 64'd0);
        chk("mrst_frame_err", 64'(frame_err), 64'd0);
        chk("mrst_frame_cnt", 64'(frame_cnt), 64'd0);
        exp_cnt = 16'd0;
        tick();
        rstn = 1'b1;
        for (int b = 3; b < LB; b++) begin
            href = 1'b1;
            data = fb[0][b];
            tick();
        end
        href = 1'b0;
        repeat (4) tick();
        send_line(1);
        vsync = 1'b1;
        repeat (4) tick();
        chk("mrst_no_beats", 64'(got.size()), 64'd0);
        chk("mrst_cnt_after", 64'(frame_cnt), 64'd0);
        good_frame("mrst_next");

        // Enable dropped while a beat is stalled.
        fill_seq(LB);
        pulse_clr();
        got.delete();
        fork
            send_frame(V);
            begin
                wait_valid("en");
                tready = 1'b0;
                enable = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    tick();
                    chk("en_held_valid", 64'(tvalid), 64'd1);
                end
                tready = 1'b1;
                tick();
                chk("en_valid_cleared", 64'(tvalid), 64'd0);
            end
        join
        chk("en_nbeats", 64'(got.size()), 64'd1);
        vsync = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        repeat (2) tick();
        got.delete();
        send_line(0);
        send_line(1);
        vsync = 1'b1;
        repeat (4) tick();
        chk("en_no_sof_beats", 64'(got.size()), 64'd0);
        chk("en_no_sof_cnt", 64'(frame_cnt), 64'(exp_cnt));
        good_frame("en_next");

        // Random frames against the reference model.
        for (int f = 0; f < 25; f++) begin
            int nl;
            int pick [9] = '{8, 8, 8, 8, 2, 3, 6, 10, 12};
            int nls [5] = '{2, 2, 2, 1, 3};
            nl = nls[$urandom_range(0, 4)];
            for (int l = 0; l < 4; l++) begin
                lens[l] = pick[$urandom_range(0, 8)];
                for (int b = 0; b < 16; b++) fb[l][b] = 8'($urandom);
            end
            pulse_clr();
            got.delete();
            build_model(nl);
            send_frame(nl);
            compare_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
